// File: rtl/keypad_matrix_scanner.sv
// Row-scanned key matrix plus function pins, single-key debounce lock and a small event FIFO
// on a valid/ready interface. Optional autorepeat of held matrix keys: KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int NUM_FUNC       = 7,
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 2,
  localparam int NUM_KEYS      = ROWS * COLS + NUM_FUNC,
  localparam int CODE_W        = $clog2(NUM_KEYS),
  localparam int FUNC_W        = (NUM_FUNC > 0) ? NUM_FUNC : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ROWS-1:0]   o_word_lines,
  input  logic [COLS-1:0]   i_bit_lines,
  input  logic [FUNC_W-1:0] i_func_pins,
  output logic [CODE_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overflow
);

  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] DEB_C = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD, ST_RELEASE} state_t;

  logic [COLS-1:0]   bit_meta_r, bit_sync_r;
  logic [FUNC_W-1:0] func_meta_r, func_sync_r;
  logic [SLOT_W-1:0] slot_r;
  logic [ROW_W-1:0]  row_r;
  logic [ROWS-1:0]   word_lines_r;
  logic              slot_end_s, frame_end_s;
  logic              row_hit_s, func_hit_s, cand_vld_s, acc_vld_r;
  logic [CODE_W-1:0] row_code_s, func_code_s, cand_code_s, acc_code_r;
  state_t            state_r, state_nx_s;
  logic [3:0]        cnt_r, cnt_nx_s;
  logic [CODE_W-1:0] key_r, key_nx_s;
  logic              push_s, rep_push_s, push_all_s;
  logic [CODE_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s, pop_s, push_ok_s, overflow_r;

  assign slot_end_s  = (slot_r == SLOT_W'(SCAN_DIV - 1));
  assign frame_end_s = slot_end_s && (row_r == ROW_W'(ROWS - 1));

  // Two-flop synchronisers for the asynchronous sense inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_meta_r  <= '0;
      bit_sync_r  <= '0;
      func_meta_r <= '0;
      func_sync_r <= '0;
    end else begin
      bit_meta_r  <= i_bit_lines;
      bit_sync_r  <= bit_meta_r;
      func_meta_r <= i_func_pins;
      func_sync_r <= func_meta_r;
    end
  end

  // Slot timer and one-hot row walker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r       <= '0;
      row_r        <= '0;
      word_lines_r <= ROWS'(1);
    end else if (slot_end_s) begin
      slot_r       <= '0;
      row_r        <= (row_r == ROW_W'(ROWS - 1)) ? '0 : row_r + ROW_W'(1);
      word_lines_r <= {word_lines_r[ROWS-2:0], word_lines_r[ROWS-1]};
    end else begin
      slot_r       <= slot_r + SLOT_W'(1);
    end
  end

  // Lowest pressed column in the driven row and lowest pressed function pin
  always_comb begin
    row_hit_s   = 1'b0;
    row_code_s  = '0;
    func_hit_s  = 1'b0;
    func_code_s = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (bit_sync_r[c]) begin
        row_hit_s  = 1'b1;
        row_code_s = CODE_W'(int'(row_r) * COLS + c);
      end else begin
        row_hit_s  = row_hit_s;
      end
    end
    for (int i = NUM_FUNC - 1; i >= 0; i--) begin
      if (func_sync_r[i]) begin
        func_hit_s  = 1'b1;
        func_code_s = CODE_W'(ROWS * COLS + i);
      end else begin
        func_hit_s  = func_hit_s;
      end
    end
  end

  // Rows are visited in ascending order, so the first hit of a frame is its lowest matrix code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld_r  <= 1'b0;
      acc_code_r <= '0;
    end else if (frame_end_s) begin
      acc_vld_r  <= 1'b0;
      acc_code_r <= '0;
    end else if (slot_end_s && !acc_vld_r && row_hit_s) begin
      acc_vld_r  <= 1'b1;
      acc_code_r <= row_code_s;
    end else begin
      acc_vld_r  <= acc_vld_r;
    end
  end

  // Frame candidate; function codes sit above every matrix code
  always_comb begin
    cand_vld_s  = 1'b1;
    cand_code_s = '0;
    if (acc_vld_r) begin
      cand_code_s = acc_code_r;
    end else if (row_hit_s) begin
      cand_code_s = row_code_s;
    end else if (func_hit_s) begin
      cand_code_s = func_code_s;
    end else begin
      cand_vld_s  = 1'b0;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      key_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      key_r   <= key_nx_s;
    end
  end

  // Debounce FSM next state, advanced only on frame boundaries
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    key_nx_s   = key_r;
    push_s     = 1'b0;
    if (frame_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (cand_vld_s) begin
            key_nx_s = cand_code_s;
            cnt_nx_s = 4'd1;
            if (DEB_C == 4'd1) begin
              state_nx_s = ST_HELD;
              push_s     = 1'b1;
            end else begin
              state_nx_s = ST_CONFIRM;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CONFIRM: begin
          if (cand_vld_s && (cand_code_s == key_r)) begin
            cnt_nx_s = cnt_r + 4'd1;
            if ((cnt_r + 4'd1) == DEB_C) begin
              state_nx_s = ST_HELD;
              push_s     = 1'b1;
            end else begin
              state_nx_s = ST_CONFIRM;
            end
          end else begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 4'd0;
          end
        end
        ST_HELD: begin
          if (!cand_vld_s) begin
            cnt_nx_s   = (DEB_C == 4'd1) ? 4'd0 : 4'd1;
            state_nx_s = (DEB_C == 4'd1) ? ST_IDLE : ST_RELEASE;
          end else begin
            state_nx_s = ST_HELD;
          end
        end
        ST_RELEASE: begin
          if (!cand_vld_s) begin
            if ((cnt_r + 4'd1) == DEB_C) begin
              state_nx_s = ST_IDLE;
              cnt_nx_s   = 4'd0;
            end else begin
              cnt_nx_s   = cnt_r + 4'd1;
            end
          end else begin
            state_nx_s = ST_HELD;
            cnt_nx_s   = 4'd0;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = 4'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] REP_DELAY_C = 8'(8 * DEBOUNCE_SCANS);
  localparam logic [7:0] REP_RATE_C  = 8'(2 * DEBOUNCE_SCANS);
  logic [7:0] rep_cnt_r, rep_cnt_nx_s;
  logic       rep_first_r, rep_first_nx_s;

  // Repeat timer: long first delay, then the shorter rate, restarted on every entry to HELD
  always_comb begin
    rep_cnt_nx_s   = rep_cnt_r;
    rep_first_nx_s = rep_first_r;
    rep_push_s     = 1'b0;
    if ((state_nx_s == ST_HELD) && (state_r != ST_HELD)) begin
      rep_cnt_nx_s   = 8'd0;
      rep_first_nx_s = 1'b1;
    end else if (frame_end_s && (state_r == ST_HELD) && (state_nx_s == ST_HELD)) begin
      if ((rep_cnt_r + 8'd1) == (rep_first_r ? REP_DELAY_C : REP_RATE_C)) begin
        rep_cnt_nx_s   = 8'd0;
        rep_first_nx_s = 1'b0;
        rep_push_s     = (int'(key_r) < ROWS * COLS);
      end else begin
        rep_cnt_nx_s   = rep_cnt_r + 8'd1;
      end
    end else begin
      rep_cnt_nx_s   = rep_cnt_r;
    end
  end

  // Repeat timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_r   <= 8'd0;
      rep_first_r <= 1'b1;
    end else begin
      rep_cnt_r   <= rep_cnt_nx_s;
      rep_first_r <= rep_first_nx_s;
    end
  end
`else
  assign rep_push_s = 1'b0;
`endif

  assign push_all_s = push_s | rep_push_s;
  assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
  assign pop_s      = (count_r != '0) && i_ready;
  assign push_ok_s  = push_all_s && (!full_s || pop_s);

  // Event FIFO; a pop in the same cycle frees room for a push into a full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= push_all_s && full_s && !pop_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= key_nx_s;
        wr_ptr_r <= (wr_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      if (push_ok_s && !pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop_s && !push_ok_s) begin
        count_r <= count_r - CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign o_word_lines = word_lines_r;
  assign o_data       = mem_r[rd_ptr_r];
  assign o_valid      = (count_r != '0);
  assign o_overflow   = overflow_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with default parameters (4x4 matrix, 7 function pins).
module tb_keypad_matrix_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] word_lines;
  logic [3:0] bit_lines;
  logic [6:0] func_pins = 7'd0;
  logic [4:0] data;
  logic       valid;
  logic       ready = 1'b1;
  logic       overflow;
  logic [15:0] keys_mat = 16'd0;

  int n_checks = 0;
  int n_fail = 0;
  int ov_cnt = 0;
  int lat;
  int ov0;
  logic [4:0] ev_q[$];

  keypad_matrix_scanner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_word_lines (word_lines),
    .i_bit_lines  (bit_lines),
    .i_func_pins  (func_pins),
    .o_data       (data),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its driven row onto its column
  always_comb begin
    bit_lines = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_mat[r*4+c] && word_lines[r]) bit_lines[c] = 1'b1;
      end
    end
  end

  // Record every accepted code and every overflow cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) ev_q.push_back(data);
      if (overflow) ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input int i);
    if (i < ev_q.size()) return 32'(ev_q[i]);
    return 'x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    tick(64 * n);
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!valid && l < 400);
  endtask

  initial begin
    // Reset values
    tick(3);
    @(negedge clk);
    check("rst_word", word_lines, 4'b0001);
    check("rst_valid", valid, 1'b0);
    check("rst_data", data, 5'd0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // Row walk, one row per 16 cycles
    repeat (15) @(negedge clk);
    check("walk_r0", word_lines, 4'b0001);
    @(negedge clk);
    check("walk_r1", word_lines, 4'b0010);
    repeat (16) @(negedge clk);
    check("walk_r2", word_lines, 4'b0100);
    repeat (16) @(negedge clk);
    check("walk_r3", word_lines, 4'b1000);
    repeat (16) @(negedge clk);
    check("walk_wrap", word_lines, 4'b0001);

    // Clean press of row 2 / col 1
    tick(1);
    ev_q.delete();
    keys_mat[9] = 1'b1;
    wait_valid(lat);
    check("press_lat_max", lat <= 259, 1'b1);
    check("press_lat_min", lat >= 128, 1'b1);
    check("press_data", data, 5'd9);
    frames(4);
    check("press_count", ev_q.size(), 1);
    check("press_code", qat(0), 9);
    keys_mat = 16'd0;
    frames(5);
    check("release_count", ev_q.size(), 1);
    keys_mat[9] = 1'b1;
    frames(5);
    check("repress_count", ev_q.size(), 2);
    check("repress_code", qat(1), 9);
    keys_mat = 16'd0;
    frames(5);

    // Bounce: toggle every frame, then hold
    ev_q.delete();
    for (int i = 0; i < 6; i++) begin
      keys_mat[9] = (i % 2 == 0);
      tick(64);
    end
    check("bounce_none", ev_q.size(), 0);
    keys_mat[9] = 1'b1;
    wait_valid(lat);
    check("bounce_lat", lat <= 259, 1'b1);
    frames(2);
    check("bounce_count", ev_q.size(), 1);
    check("bounce_code", qat(0), 9);
    keys_mat = 16'd0;
    frames(5);

    // Function pin 6 together with key 0, then pin 6 alone
    ev_q.delete();
    func_pins[6] = 1'b1;
    keys_mat[0] = 1'b1;
    frames(7);
    check("func_mix_count", ev_q.size(), 1);
    check("func_mix_code", qat(0), 0);
    func_pins = 7'd0;
    keys_mat = 16'd0;
    frames(5);
    check("func_rel_count", ev_q.size(), 1);
    func_pins[6] = 1'b1;
    frames(5);
    check("func_count", ev_q.size(), 2);
    check("func_code", qat(1), 22);
    func_pins = 7'd0;
    frames(5);

    // Backpressure: three presses into a two-entry queue
    ev_q.delete();
    ready = 1'b0;
    ov0 = ov_cnt;
    keys_mat[1] = 1'b1;  frames(5); keys_mat = 16'd0; frames(5);
    keys_mat[5] = 1'b1;  frames(5); keys_mat = 16'd0; frames(5);
    check("bp_no_ovf", ov_cnt - ov0, 0);
    keys_mat[14] = 1'b1; frames(5); keys_mat = 16'd0; frames(5);
    @(negedge clk);
    check("bp_ovf", ov_cnt - ov0, 1);
    check("bp_valid", valid, 1'b1);
    check("bp_head", data, 5'd1);
    tick(1);
    ready = 1'b1;
    tick(4);
    @(negedge clk);
    check("bp_pop_count", ev_q.size(), 2);
    check("bp_pop0", qat(0), 1);
    check("bp_pop1", qat(1), 5);
    check("bp_empty", valid, 1'b0);

    // Reset during CONFIRM with one event queued
    tick(1);
    ready = 1'b0;
    keys_mat[3] = 1'b1; frames(5); keys_mat = 16'd0; frames(5);
    @(negedge clk);
    check("mid_queued", valid, 1'b1);
    check("mid_head", data, 5'd3);
    tick(1);
    keys_mat[7] = 1'b1;
    tick(96);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_word", word_lines, 4'b0001);
    check("mid_rst_data", data, 5'd0);
    ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(lat);
    check("post_rst_lat", lat, 192);
    check("post_rst_code", data, 5'd7);
    keys_mat = 16'd0;
    frames(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
